// File: rtl/hub75_pixel_fetch_if.sv
// Framebuffer read ports and pixel stream shared by hub75_pixel_fetch (master) and RAM/driver (slave).
// With FRAME_SWAP_EN defined the RAM addresses gain a bank MSB.
interface hub75_pixel_fetch_if #(
  parameter int k_width      = 64,
  parameter int k_height     = 64,
  parameter int k_color_bits = 8
);
  localparam int CW = $clog2(k_width);
  localparam int RW = $clog2(k_height / 2);
  localparam int PW = $clog2(k_color_bits);
`ifdef FRAME_SWAP_EN
  localparam int AW = $clog2(k_width * k_height) + 1;
`else
  localparam int AW = $clog2(k_width * k_height);
`endif

  logic                      mem_en;
  logic [AW-1:0]             mem_addr_t;
  logic [AW-1:0]             mem_addr_b;
  logic [3*k_color_bits-1:0] mem_data_t;
  logic [3*k_color_bits-1:0] mem_data_b;
  logic                      px_valid;
  logic                      px_ready;
  logic [5:0]                px_rgb;
  logic [CW-1:0]             px_col;
  logic [RW-1:0]             px_row;
  logic [PW-1:0]             px_plane;
  logic                      px_last;
  logic                      px_frame_end;

  modport master (
    output mem_en, mem_addr_t, mem_addr_b,
    input  mem_data_t, mem_data_b,
    output px_valid,
    input  px_ready,
    output px_rgb, px_col, px_row, px_plane, px_last, px_frame_end
  );

  modport slave (
    input  mem_en, mem_addr_t, mem_addr_b,
    output mem_data_t, mem_data_b,
    input  px_valid,
    output px_ready,
    input  px_rgb, px_col, px_row, px_plane, px_last, px_frame_end
  );
endinterface

// File: rtl/hub75_pixel_fetch.sv
// Scan-order framebuffer reader feeding the HUB-75 driver with bitplane pixel pairs.
// Optional FRAME_SWAP_EN: double-buffered framebuffer, bank toggles after a requested frame ends.
module hub75_pixel_fetch #(
  parameter int k_width      = 64,
  parameter int k_height     = 64,
  parameter int k_color_bits = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
`ifdef FRAME_SWAP_EN
  input  logic swap_req_i,
  output logic bank_o,
`endif
  output logic busy_o,
  hub75_pixel_fetch_if.master bus
);
  localparam int CB = k_color_bits;
  localparam int CW = $clog2(k_width);
  localparam int RW = $clog2(k_height / 2);
  localparam int PW = $clog2(k_color_bits);
  localparam logic [CW-1:0] COL_LAST   = CW'(k_width - 1);
  localparam logic [PW-1:0] PLANE_LAST = PW'(k_color_bits - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(k_height / 2 - 1);

  typedef struct packed {
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [PW-1:0] plane;
    logic          last;
    logic          frame_end;
  } tag_t;

  typedef struct packed {
    logic [5:0] rgb;
    tag_t       tag;
  } item_t;

  logic [CW-1:0] col_q, col_d;
  logic [PW-1:0] plane_q, plane_d;
  logic [RW-1:0] row_q, row_d;
  logic          inflight_q;
  tag_t          tag_q;
  tag_t          tag_now;
  item_t         fifo_q [2];
  item_t         head;
  logic          rd_ptr_q, wr_ptr_q;
  logic [1:0]    cnt_q;
  logic [1:0]    load_after_pop;
  logic          issue, push, pop;
  logic [5:0]    rgb_in;
  logic [CB-1:0] r_t, g_t, b_t, r_b, g_b, b_b;

  assign push = inflight_q;
  assign pop  = (cnt_q != 2'd0) && bus.px_ready;

  // The slot freed by this cycle's pop counts as a credit, giving back-to-back issue.
  assign load_after_pop = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue = rst_ni && (run_i || (col_q != '0)) && (load_after_pop < 2'd2);

  assign tag_now.col       = col_q;
  assign tag_now.row       = row_q;
  assign tag_now.plane     = plane_q;
  assign tag_now.last      = (col_q == COL_LAST);
  assign tag_now.frame_end = (col_q == COL_LAST) && (plane_q == PLANE_LAST) && (row_q == ROW_LAST);

  always_comb begin
    col_d   = col_q;
    plane_d = plane_q;
    row_d   = row_q;
    if (issue) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (plane_q == PLANE_LAST) begin
          plane_d = '0;
          row_d   = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end else begin
          plane_d = plane_q + PW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  assign {r_t, g_t, b_t} = bus.mem_data_t;
  assign {r_b, g_b, b_b} = bus.mem_data_b;
  assign rgb_in = {r_t[tag_q.plane], g_t[tag_q.plane], b_t[tag_q.plane],
                   r_b[tag_q.plane], g_b[tag_q.plane], b_b[tag_q.plane]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q      <= '0;
      plane_q    <= '0;
      row_q      <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      col_q      <= col_d;
      plane_q    <= plane_d;
      row_q      <= row_d;
      inflight_q <= issue;
      if (issue) tag_q <= tag_now;
      if (push) begin
        fifo_q[wr_ptr_q] <= item_t'{rgb: rgb_in, tag: tag_q};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef FRAME_SWAP_EN
  logic bank_q, pend_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_q <= 1'b0;
      pend_q <= 1'b0;
    end else if (issue && tag_now.frame_end && pend_q) begin
      bank_q <= ~bank_q;
      pend_q <= 1'b0;
    end else if (swap_req_i) begin
      pend_q <= 1'b1;
    end
  end

  assign bank_o         = bank_q;
  assign bus.mem_addr_t = issue ? {bank_q, 1'b0, row_q, col_q} : '0;
  assign bus.mem_addr_b = issue ? {bank_q, 1'b1, row_q, col_q} : '0;
`else
  assign bus.mem_addr_t = issue ? {1'b0, row_q, col_q} : '0;
  assign bus.mem_addr_b = issue ? {1'b1, row_q, col_q} : '0;
`endif

  assign bus.mem_en       = issue;
  assign head             = fifo_q[rd_ptr_q];
  assign bus.px_valid     = (cnt_q != 2'd0);
  assign bus.px_rgb       = head.rgb;
  assign bus.px_col       = head.tag.col;
  assign bus.px_row       = head.tag.row;
  assign bus.px_plane     = head.tag.plane;
  assign bus.px_last      = head.tag.last;
  assign bus.px_frame_end = head.tag.frame_end;
  assign busy_o           = inflight_q | (cnt_q != 2'd0);
endmodule
